// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream style frame FIFO.
// A stored beat is packed as {data, sof, eol}. The flags sit in the low
// bits so their offsets do not depend on the data width.
package axis_pkg;

    // Number of sideband flag bits stored alongside each beat (sof, eol).
    localparam int unsigned AxisFlagW   = 2;

    // Bit offsets of the fields inside a stored beat word.
    localparam int unsigned AxisEolOff  = 0;
    localparam int unsigned AxisSofOff  = 1;
    localparam int unsigned AxisDataOff = AxisFlagW;

    // Width of one stored beat for a given data width.
    function automatic int unsigned axis_word_w(input int unsigned data_w);
        return data_w + AxisFlagW;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_frame_fifo: a Depth x DataW dual-port array with
// one write port and one registered read port. A read of the address
// being written in the same cycle returns the new data. The top relies on
// this to present a freshly written beat on the output one cycle later.
// The read register is cleared by reset so the downstream data is
// well-defined; the array itself holds no reset.
module axis_fifo_mem #(
    parameter int unsigned DataW = 10,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_addr_i,
    input  logic [DataW-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(Depth)-1:0] rd_addr_i,
    output logic [DataW-1:0]         rd_data_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rd_data_q;
    logic [DataW-1:0] rd_data_d;

    // Write port: store the incoming beat at the write address.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-port next value: forward the write data on an address collision.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_addr_i];
            end
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// Frame-aware stream FIFO. Beats carry data plus sof (start of frame)
// and eol (end of line) flags. The flags travel with the data unchanged.
// The input side counts eol beats per frame and raises a sticky frame_err
// when a frame closes with the wrong line count, or when an eol arrives
// before any frame was started. Errors never stall or drop data.
//
// Handshake: a beat moves on an edge where valid && ready are both high.
// valid must not depend on ready. The producer holds a beat stable until
// it is taken. m_data/m_sof/m_eol stay stable while m_valid && !m_ready.
//
// The level output counts every stored beat, including the one presented
// on the m_* outputs. The head beat always lives in the registered read
// port of the storage. m_valid is therefore simply "level != 0".
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module axis_frame_fifo #(
    parameter int unsigned Width         = 8,
    parameter int unsigned Depth         = 16,
    parameter int unsigned LinesPerFrame = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Width-1:0]           s_data,
    input  logic                       s_sof,
    input  logic                       s_eol,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [Width-1:0]           m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic                       frame_err,
    input  logic                       err_clr
);

    import axis_pkg::*;

    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned LevelW = $clog2(Depth + 1);
    localparam int unsigned LineW  = $clog2(LinesPerFrame + 1);
    localparam int unsigned WordW  = axis_word_w(Width);

    localparam logic [LevelW-1:0] LevelFull  = LevelW'(Depth);
    localparam logic [LevelW-1:0] LevelOne   = LevelW'(1);
    localparam logic [LineW-1:0]  LineTarget = LineW'(LinesPerFrame);
    localparam logic [LineW-1:0]  LineMax    = '1;

    // Datapath and control state.
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;

    // Frame geometry state.
    logic [LineW-1:0]  line_cnt_q, line_cnt_d;
    logic              frame_open_q, frame_open_d;
    logic              frame_err_q, frame_err_d;
    logic              err_set;

    // Handshake and storage interface.
    logic              wr_fire;
    logic              rd_fire;
    logic              head_load;
    logic [AddrW-1:0]  head_addr;
    logic [WordW-1:0]  wr_word;
    logic [WordW-1:0]  rd_word;

    assign wr_fire = s_valid && s_ready_q;
    assign rd_fire = m_valid_q && m_ready;

    // Pack the incoming beat into a storage word.
    always_comb begin
        wr_word                         = '0;
        wr_word[AxisDataOff +: Width]   = s_data;
        wr_word[AxisSofOff]             = s_sof;
        wr_word[AxisEolOff]             = s_eol;
    end

    // Occupancy, pointers and the registered ready/valid flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LevelOne;
            2'b01:   level_d = level_q - LevelOne;
            default: level_d = level_q;
        endcase
        s_ready_d = (level_d < LevelFull);
        m_valid_d = (level_d != '0);
    end

    // Refill the output register when the head changes: after a read that
    // leaves a beat behind (possibly the one written this same edge), or
    // when a beat lands in an empty FIFO.
    always_comb begin
        head_addr = rd_fire ? (rd_ptr_q + AddrW'(1)) : rd_ptr_q;
        head_load = (rd_fire && ((level_q > LevelOne) || wr_fire))
                 || ((level_q == '0) && wr_fire);
    end

    // Line counting and error detection on the accepted input beat.
    // A sof+eol beat opens the frame and then counts as its first line.
    always_comb begin
        line_cnt_d   = line_cnt_q;
        frame_open_d = frame_open_q;
        err_set      = 1'b0;
        if (wr_fire) begin
            if (s_sof) begin
                if (frame_open_q && (line_cnt_q != LineTarget)) begin
                    err_set = 1'b1;
                end
                frame_open_d = 1'b1;
                line_cnt_d   = s_eol ? LineW'(1) : '0;
            end else if (s_eol) begin
                if (!frame_open_q) begin
                    err_set = 1'b1;
                end
                if (line_cnt_q != LineMax) begin
                    line_cnt_d = line_cnt_q + LineW'(1);
                end
            end
        end
        // A new error in the same cycle as a clear wins.
        if (err_set) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // State registers; reset empties the FIFO and forgets any open frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            line_cnt_q   <= '0;
            frame_open_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            line_cnt_q   <= line_cnt_d;
            frame_open_q <= frame_open_d;
            frame_err_q  <= frame_err_d;
        end
    end

    axis_fifo_mem #(
        .DataW (WordW),
        .Depth (Depth)
    ) u_mem (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_word),
        .rd_en_i   (head_load),
        .rd_addr_i (head_addr),
        .rd_data_o (rd_word)
    );

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = rd_word[AxisDataOff +: Width];
    assign m_sof     = rd_word[AxisSofOff];
    assign m_eol     = rd_word[AxisEolOff];
    assign level     = level_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo with Width=8, Depth=4, LinesPerFrame=2.
module tb_axis_frame_fifo;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LPF = 2;
  localparam int LW  = $clog2(D + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  s_data = '0;
  logic          s_sof = 1'b0, s_eol = 1'b0, s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_sof, m_eol, m_valid;
  logic          m_ready = 1'b0;
  logic [LW-1:0] level;
  logic          frame_err;
  logic          err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {data, sof, eol}

  axis_frame_fifo #(.Width(W), .Depth(D), .LinesPerFrame(LPF)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .frame_err(frame_err), .err_clr(err_clr)
  );

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (s_ready !== 1'b0)   begin n_err++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    n_vec++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_vec++; if ({m_data, m_sof, m_eol} !== '0) begin n_err++; $display("FAIL reset_m_beat got=%h exp=0", {m_data, m_sof, m_eol}); end
    n_vec++; if (level !== '0)       begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst = 1'b1;
    tick();
    n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL reset_ready_rise got=%b exp=1", s_ready); end
    // eol before any sof since reset
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h77; s_eol = 1'b1;
    tick();
    s_valid = 1'b0; s_eol = 1'b0;
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL orphan_eol_err got=%b exp=1", frame_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; m_ready = 1'b0;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL orphan_eol_clr got=%b exp=0", frame_err); end
    n_vec++; if (level !== '0)       begin n_err++; $display("FAIL orphan_eol_level got=%0d exp=0", level); end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = vals[i];
      tick();
    end
    // keep offering a beat while full: it must not get in
    s_data = 8'h55;
    tick();
    tick();
    s_valid = 1'b0;
    n_vec++; if (level !== LW'(4))  begin n_err++; $display("FAIL fill_level got=%0d exp=4", level); end
    n_vec++; if (s_ready !== 1'b0)  begin n_err++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
    n_vec++; if (m_data !== 8'h11)  begin n_err++; $display("FAIL fill_head got=%h exp=11", m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== vals[i]) begin
        n_err++; $display("FAIL drain_beat%0d got=%b/%h exp=1/%h", i, m_valid, m_data, vals[i]);
      end
      tick();
    end
    m_ready = 1'b0;
    n_vec++; if (level !== '0)     begin n_err++; $display("FAIL drain_level got=%0d exp=0", level); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_m_valid got=%b exp=0", m_valid); end
  endtask

  task automatic test_latency();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL lat_m_valid got=%b exp=1", m_valid); end
    n_vec++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL lat_m_data got=%h exp=a5", m_data); end
    n_vec++; if (level !== LW'(1)) begin n_err++; $display("FAIL lat_level got=%0d exp=1", level); end
    // stalled head must hold
    tick();
    n_vec++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL lat_hold got=%h exp=a5", m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL lat_drain got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nxt;
    logic [W+1:0] w;
    int delivered;
    int cyc;
    nxt = 8'h40; delivered = 0;
    exp_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = nxt;
      exp_q.push_back({nxt, 2'b00}); nxt++;
      tick();
    end
    n_vec++; if (level !== LW'(4)) begin n_err++; $display("FAIL b2b_full got=%0d exp=4", level); end
    // full, both sides active for 20 cycles across pointer wrap
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1; s_data = nxt; m_ready = 1'b1;
      if (m_valid && m_ready) begin
        n_vec++; delivered++;
        w = exp_q.pop_front();
        if ({m_data, m_sof, m_eol} !== w) begin n_err++; $display("FAIL b2b_beat got=%h exp=%h", {m_data, m_sof, m_eol}, w); end
      end
      if (s_valid && s_ready) begin exp_q.push_back({nxt, 2'b00}); nxt++; end
      tick();
    end
    s_valid = 1'b0;
    n_vec++; if (delivered != 20) begin n_err++; $display("FAIL b2b_count got=%0d exp=20", delivered); end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      if (m_valid) begin
        n_vec++;
        w = exp_q.pop_front();
        if ({m_data, m_sof, m_eol} !== w) begin n_err++; $display("FAIL b2b_tail got=%h exp=%h", {m_data, m_sof, m_eol}, w); end
      end
      tick(); cyc++;
    end
    m_ready = 1'b0;
    n_vec++; if (level !== '0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_end level=%0d left=%0d exp=0/0", level, exp_q.size()); end
  endtask

  task automatic test_frame_geometry();
    // columns: valid, sof, eol, clr, expected frame_err after the edge
    logic [4:0] tbl [14];
    logic [W-1:0] d;
    tbl[0]  = 5'b1_1_0_0_0; tbl[1]  = 5'b1_0_1_0_0; tbl[2]  = 5'b1_0_1_0_0;
    tbl[3]  = 5'b1_1_0_0_0; tbl[4]  = 5'b1_0_1_0_0; tbl[5]  = 5'b1_1_0_0_1;
    tbl[6]  = 5'b0_0_0_1_0; tbl[7]  = 5'b1_0_1_0_0; tbl[8]  = 5'b1_0_1_0_0;
    tbl[9]  = 5'b1_1_1_0_0; tbl[10] = 5'b1_0_1_0_0; tbl[11] = 5'b1_1_0_0_0;
    tbl[12] = 5'b1_1_0_1_1; tbl[13] = 5'b0_0_0_1_0;
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d = 8'h80 + 8'(i);
      s_valid = tbl[i][4]; s_sof = tbl[i][3]; s_eol = tbl[i][2]; err_clr = tbl[i][1]; s_data = d;
      tick();
      n_vec++; if (frame_err !== tbl[i][0]) begin n_err++; $display("FAIL geom_err%0d got=%b exp=%b", i, frame_err, tbl[i][0]); end
      if (tbl[i][4]) begin
        n_vec++;
        if ({m_valid, m_data, m_sof, m_eol} !== {1'b1, d, tbl[i][3], tbl[i][2]}) begin
          n_err++; $display("FAIL geom_beat%0d got=%h exp=%h", i, {m_valid, m_data, m_sof, m_eol}, {1'b1, d, tbl[i][3], tbl[i][2]});
        end
      end
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; err_clr = 1'b0;
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL geom_level got=%0d exp=0", level); end
    m_ready = 1'b0;
  endtask

  task automatic test_random_then_reset();
    logic [W+1:0] w;
    int acc;
    int cyc;
    acc = 0; cyc = 0;
    exp_q.delete();
    while ((acc < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (acc < 1000) begin
        s_valid = 1'($urandom_range(0, 1)); s_data = 8'($urandom_range(0, 255));
        s_sof = 1'($urandom_range(0, 1)); s_eol = 1'($urandom_range(0, 1));
      end else begin
        s_valid = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_beat got=%h exp=none", {m_data, m_sof, m_eol});
        end else begin
          w = exp_q.pop_front();
          if ({m_data, m_sof, m_eol} !== w) begin n_err++; $display("FAIL rand_beat got=%h exp=%h", {m_data, m_sof, m_eol}, w); end
        end
      end
      if (s_valid && s_ready) begin exp_q.push_back({s_data, s_sof, s_eol}); acc++; end
      tick(); cyc++;
      n_vec++; if (level !== LW'(exp_q.size())) begin n_err++; $display("FAIL rand_level got=%0d exp=%0d", level, exp_q.size()); end
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    n_vec++; if (cyc >= 20000) begin n_err++; $display("FAIL rand_timeout got=%0d cycles exp<20000", cyc); end
    // open a frame with one line, leave it stored, then reset
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A; s_sof = 1'b1;
    tick();
    s_data = 8'h5B; s_sof = 1'b0; s_eol = 1'b1;
    tick();
    s_valid = 1'b0; s_eol = 1'b0;
    n_vec++; if (level !== LW'(2)) begin n_err++; $display("FAIL mid_level got=%0d exp=2", level); end
    rst = 1'b0;
    #1;
    n_vec++; if (s_ready !== 1'b0)   begin n_err++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    n_vec++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    n_vec++; if ({m_data, m_sof, m_eol} !== '0) begin n_err++; $display("FAIL rst_m_beat got=%h exp=0", {m_data, m_sof, m_eol}); end
    n_vec++; if (level !== '0)       begin n_err++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise got=%b exp=1", s_ready); end
    // first sof after reset is not a geometry error
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h01; s_sof = 1'b1;
    tick();
    s_sof = 1'b0; s_valid = 1'b0;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL post_rst_sof_err got=%b exp=0", frame_err); end
    n_vec++; if ({m_valid, m_data, m_sof} !== {1'b1, 8'h01, 1'b1}) begin n_err++; $display("FAIL post_rst_beat got=%h exp=%h", {m_valid, m_data, m_sof}, {1'b1, 8'h01, 1'b1}); end
    tick();
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL post_rst_level got=%0d exp=0", level); end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_frame_geometry();
    test_random_then_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end
endmodule
